// File: rtl/regfile_wr_arbiter_pkg.sv
// rtl/regfile_wr_arbiter_pkg.sv - shared types and defaults for the register-file write arbiter
package regfile_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  typedef struct packed {
    logic [AW_DEF-1:0] wa;
    logic [DW_DEF-1:0] wd;
  } wr_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } issue_state_t;

endpackage

// File: rtl/regfile_wr_arbiter_skid.sv
// rtl/regfile_wr_arbiter_skid.sv - one-entry valid/ready buffer for a writeback requester
module wr_skid_buf
  import regfile_pkg::*;
#(
  parameter type T = wr_req_t
) (
  input  logic clk,
  input  logic rstn,
  input  logic push_valid,
  output logic push_ready,
  input  T     push_data,
  input  logic drop,
  output logic pop_valid,
  input  logic pop_ready,
  output T     pop_data
);

  logic valid_q;
  T     data_q;
  logic load;

  // Accept when empty or when the held entry leaves this cycle; a dropped
  // transfer still handshakes but never occupies the entry.
  assign push_ready = ~valid_q | pop_ready;
  assign load       = push_valid & push_ready & ~drop;
  assign pop_valid  = valid_q;
  assign pop_data   = data_q;

  // Entry register: refill has priority over drain so a granted entry can be replaced in the same edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= push_data;
    end else if (pop_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-requester arbiter for the register-file write port (optional REGFILE_ZERO_PROTECT_EN)
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int AW         = AW_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_wa,
  input  logic [DW-1:0] a_wd,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_wa,
  input  logic [DW-1:0] b_wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          ra1_pend,
  output logic          ra2_pend,
  output logic          rf_rwe,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic          busy
);

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } req_t;

  req_t         a_buf, b_buf, issue_q;
  logic         a_bv, b_bv;
  logic         gnt_a, gnt_b;
  logic         prio_b;
  logic         drop_a, drop_b;
  issue_state_t state_q, next_state;

`ifdef REGFILE_ZERO_PROTECT_EN
  assign drop_a = (a_wa == '0);
  assign drop_b = (b_wa == '0);
`else
  assign drop_a = 1'b0;
  assign drop_b = 1'b0;
`endif

  wr_skid_buf #(.T(req_t)) u_buf_a (
    .clk        (clk),
    .rstn       (rstn),
    .push_valid (a_valid),
    .push_ready (a_ready),
    .push_data  ({a_wa, a_wd}),
    .drop       (drop_a),
    .pop_valid  (a_bv),
    .pop_ready  (gnt_a),
    .pop_data   (a_buf)
  );

  wr_skid_buf #(.T(req_t)) u_buf_b (
    .clk        (clk),
    .rstn       (rstn),
    .push_valid (b_valid),
    .push_ready (b_ready),
    .push_data  ({b_wa, b_wd}),
    .drop       (drop_b),
    .pop_valid  (b_bv),
    .pop_ready  (gnt_b),
    .pop_data   (b_buf)
  );

  // Grant from buffer valids only, so no combinational path from VALID to READY
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (a_bv && b_bv) begin
      if (FIXED_PRIO != 0 || !prio_b) gnt_a = 1'b1;
      else                            gnt_b = 1'b1;
    end else begin
      gnt_a = a_bv;
      gnt_b = b_bv;
    end
  end

  // Round-robin pointer: after a grant the other side is preferred next
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      prio_b <= 1'b0;
    else if (gnt_a) prio_b <= 1'b1;
    else if (gnt_b) prio_b <= 1'b0;
  end

  // Issue FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= next_state;
  end

  // Issue FSM next state: any grant produces a write next cycle, so the port never stalls
  always_comb begin
    next_state = IDLE;
    if (gnt_a || gnt_b) next_state = WRITE;
  end

  // Issue register captures the granted entry; it holds its value while idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      issue_q <= '0;
    else if (gnt_a) issue_q <= a_buf;
    else if (gnt_b) issue_q <= b_buf;
  end

  assign rf_rwe = (state_q == WRITE);
  assign rf_wa  = issue_q.wa;
  assign rf_wd  = issue_q.wd;
  assign busy   = a_bv | b_bv | rf_rwe;

  // Stale-read detection against every in-flight write
  always_comb begin
    ra1_pend = (a_bv && a_buf.wa == ra1) || (b_bv && b_buf.wa == ra1) ||
               (rf_rwe && issue_q.wa == ra1);
    ra2_pend = (a_bv && a_buf.wa == ra2) || (b_bv && b_buf.wa == ra2) ||
               (rf_rwe && issue_q.wa == ra2);
`ifdef REGFILE_ZERO_PROTECT_EN
    if (ra1 == '0) ra1_pend = 1'b0;
    if (ra2 == '0) ra2_pend = 1'b0;
`endif
  end

endmodule
